// File: rtl/y86_alu_pkg.sv
// Shared definitions for the Y86 execute-stage adder/subtractor: op encoding,
// condition-flag bundle and the signed-overflow rule.
package y86_alu_pkg;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  typedef struct packed {
    logic zf;
    logic sf;
    logic of;
    logic cf;
  } flags_t;

  // SUB adds ~B, so overflow needs operands of opposite sign
  function automatic logic calc_of(input logic op, input logic a_msb,
                                   input logic b_msb, input logic r_msb);
    if (op == OP_SUB) return (a_msb != b_msb) && (r_msb != a_msb);
    return (a_msb == b_msb) && (r_msb != a_msb);
  endfunction

endpackage

// File: rtl/pipelined_addsub_if.sv
// Operand/result handshake bundle for pipelined_addsub.
interface pipelined_addsub_if #(
  parameter int unsigned WIDTH = 64
);
  logic             in_valid;
  logic             in_ready;
  logic             op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             zf;
  logic             sf;
  logic             of;
  logic             cf;

  modport slave (
    input  in_valid, op, a, b, out_ready,
    output in_ready, out_valid, result, zf, sf, of, cf
  );

  modport master (
    output in_valid, op, a, b, out_ready,
    input  in_ready, out_valid, result, zf, sf, of, cf
  );
endinterface

// File: rtl/pipelined_addsub_csel.sv
// One carry-select segment: two ripple sums (cin=0 / cin=1) and a late select.
module csel_segment #(
  parameter int unsigned SEG_W = 16
) (
  input  logic [SEG_W-1:0] a_seg,
  input  logic [SEG_W-1:0] b_seg,
  input  logic             cin,
  output logic [SEG_W-1:0] sum,
  output logic             cout,
  output logic             zero
);
  logic [SEG_W-1:0] s0, s1;
  logic             c0, c1;

  always_comb begin
    s0 = '0;
    s1 = '0;
    c0 = 1'b0;
    c1 = 1'b1;
    for (int unsigned i = 0; i < SEG_W; i++) begin
      s0[i] = a_seg[i] ^ b_seg[i] ^ c0;
      c0    = (a_seg[i] & b_seg[i]) | (c0 & (a_seg[i] ^ b_seg[i]));
      s1[i] = a_seg[i] ^ b_seg[i] ^ c1;
      c1    = (a_seg[i] & b_seg[i]) | (c1 & (a_seg[i] ^ b_seg[i]));
    end
  end

  assign sum  = cin ? s1 : s0;
  assign cout = cin ? c1 : c0;
  assign zero = (sum == '0);
endmodule

// File: rtl/pipelined_addsub.sv
// Pipelined carry-select add/sub for the Y86 execute stage; one SEG_W segment
// is resolved per stage, with a stall-all valid/ready handshake.
module pipelined_addsub
  import y86_alu_pkg::*;
#(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned SEG_W = 16
) (
  input logic              clk,
  input logic              rst_n,
  pipelined_addsub_if.slave bus
);
  localparam int unsigned NSEG = WIDTH / SEG_W;

  if ((SEG_W == 0) || (WIDTH % SEG_W != 0) || (NSEG < 1)) begin : g_bad_param
    $error("pipelined_addsub: WIDTH must be a non-zero multiple of SEG_W");
  end

  logic             adv;
  logic [WIDTH-1:0] bx;
  flags_t           fl;

  assign adv          = !bus.out_valid || bus.out_ready;
  assign bus.in_ready = adv;
  assign bx           = (bus.op == OP_SUB) ? ~bus.b : bus.b;

  for (genvar k = 0; k < NSEG; k++) begin : g_st
    // RW: operand bits still unresolved entering stage k; LW: result bits held after it
    localparam int unsigned RW = WIDTH - k * SEG_W;
    localparam int unsigned LW = (k + 1) * SEG_W;

    logic [RW-1:0]    ra, rb;
    logic             ci, pv, pz, pop, pam, pbm;
    logic [SEG_W-1:0] ss;
    logic             co, z;
    logic [LW-1:0]    nrs;

    logic             v_q, cy_q, zr_q, op_q, am_q, bm_q;
    logic [LW-1:0]    rs_q;

    if (k == 0) begin : g_head
      assign ra  = bus.a;
      assign rb  = bx;
      assign ci  = bus.op;
      assign pv  = bus.in_valid;
      assign pz  = 1'b1;
      assign pop = bus.op;
      assign pam = bus.a[WIDTH-1];
      assign pbm = bus.b[WIDTH-1];
      assign nrs = ss;
    end else begin : g_body
      assign ra  = g_st[k-1].g_skew.a_q;
      assign rb  = g_st[k-1].g_skew.b_q;
      assign ci  = g_st[k-1].cy_q;
      assign pv  = g_st[k-1].v_q;
      assign pz  = g_st[k-1].zr_q;
      assign pop = g_st[k-1].op_q;
      assign pam = g_st[k-1].am_q;
      assign pbm = g_st[k-1].bm_q;
      assign nrs = {ss, g_st[k-1].rs_q};
    end

    csel_segment #(.SEG_W(SEG_W)) u_seg (
      .a_seg (ra[SEG_W-1:0]),
      .b_seg (rb[SEG_W-1:0]),
      .cin   (ci),
      .sum   (ss),
      .cout  (co),
      .zero  (z)
    );

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        v_q  <= 1'b0;
        rs_q <= '0;
        cy_q <= 1'b0;
        zr_q <= 1'b0;
        op_q <= OP_ADD;
        am_q <= 1'b0;
        bm_q <= 1'b0;
      end else if (adv) begin
        v_q  <= pv;
        rs_q <= nrs;
        cy_q <= co;
        zr_q <= pz & z;
        op_q <= pop;
        am_q <= pam;
        bm_q <= pbm;
      end
    end

    // Upper operand segments ride along unreset; only v_q gates their use
    if (k < NSEG - 1) begin : g_skew
      logic [RW-SEG_W-1:0] a_q, b_q;

      always_ff @(posedge clk) begin
        if (adv) begin
          a_q <= ra[RW-1:SEG_W];
          b_q <= rb[RW-1:SEG_W];
        end
      end
    end
  end

  always_comb begin
    fl    = '0;
    fl.zf = g_st[NSEG-1].zr_q;
    fl.sf = g_st[NSEG-1].rs_q[WIDTH-1];
    fl.cf = g_st[NSEG-1].cy_q;
    fl.of = calc_of(g_st[NSEG-1].op_q, g_st[NSEG-1].am_q,
                    g_st[NSEG-1].bm_q, g_st[NSEG-1].rs_q[WIDTH-1]);
  end

  assign bus.out_valid = g_st[NSEG-1].v_q;
  assign bus.result    = g_st[NSEG-1].rs_q;
  assign bus.zf        = fl.zf;
  assign bus.sf        = fl.sf;
  assign bus.of        = fl.of;
  assign bus.cf        = fl.cf;
endmodule

// File: tb/tb_pipelined_addsub.sv
// Self-checking bench for pipelined_addsub: arithmetic reference model with an
// in-order scoreboard, directed corner cases and randomized traffic.
module tb_pipelined_addsub;
  import y86_alu_pkg::*;

  localparam int unsigned W = 64;

  typedef struct packed {
    logic [W-1:0] r;
    logic         zf;
    logic         sf;
    logic         of;
    logic         cf;
  } obs_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pipelined_addsub_if #(.WIDTH(W)) bus   ();
  pipelined_addsub_if #(.WIDTH(W)) bus_w ();
  pipelined_addsub_if #(.WIDTH(W)) bus_n ();

  pipelined_addsub #(.WIDTH(W), .SEG_W(16)) dut   (.clk(clk), .rst_n(rst_n), .bus(bus.slave));
  pipelined_addsub #(.WIDTH(W), .SEG_W(64)) dut_w (.clk(clk), .rst_n(rst_n), .bus(bus_w.slave));
  pipelined_addsub #(.WIDTH(W), .SEG_W(8))  dut_n (.clk(clk), .rst_n(rst_n), .bus(bus_n.slave));

  obs_t cur, cur_w, cur_n;
  assign cur   = {bus.result,   bus.zf,   bus.sf,   bus.of,   bus.cf};
  assign cur_w = {bus_w.result, bus_w.zf, bus_w.sf, bus_w.of, bus_w.cf};
  assign cur_n = {bus_n.result, bus_n.zf, bus_n.sf, bus_n.of, bus_n.cf};

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  obs_t q[$];
  logic hold_v = 1'b0;
  obs_t held;

  // Plain integer arithmetic: unsigned for result/carry, signed for overflow
  function automatic obs_t model(input logic op, input logic [W-1:0] a, input logic [W-1:0] b);
    obs_t                e;
    logic [W:0]          u;
    logic signed [W+1:0] s;
    logic signed [W+1:0] sr;
    if (op == OP_ADD) begin
      u    = {1'b0, a} + {1'b0, b};
      s    = $signed({{2{a[W-1]}}, a}) + $signed({{2{b[W-1]}}, b});
      e.cf = u[W];
    end else begin
      u    = {1'b0, a} - {1'b0, b};
      s    = $signed({{2{a[W-1]}}, a}) - $signed({{2{b[W-1]}}, b});
      e.cf = (a >= b);
    end
    e.r  = u[W-1:0];
    e.zf = (e.r == '0);
    e.sf = e.r[W-1];
    sr   = $signed({{2{e.r[W-1]}}, e.r});
    e.of = (s != sr);
    return e;
  endfunction

  function automatic logic [W-1:0] pick();
    logic [W-1:0] v;
    case ($urandom_range(6))
      0:       v = '0;
      1:       v = '1;
      2:       v = 64'h8000_0000_0000_0000;
      3:       v = 64'h7FFF_FFFF_FFFF_FFFF;
      4:       v = {48'h0, 16'(1 << $urandom_range(15))} - 64'd1;
      default: v = {$urandom, $urandom};
    endcase
    return v;
  endfunction

  task automatic check(input string name, input logic [W+3:0] act, input logic [W+3:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  // Scoreboard: evaluated mid-cycle, predicting what the next rising edge does
  always @(negedge clk) begin
    if (!rst_n) begin
      q.delete();
      hold_v = 1'b0;
    end else begin
      check_bit("in_ready", bus.in_ready, !bus.out_valid || bus.out_ready);
      if (hold_v) check("stall_hold", cur, held);
      hold_v = bus.out_valid && !bus.out_ready;
      held   = cur;
      if (bus.out_valid && bus.out_ready) begin
        if (q.size() == 0) check_bit("spurious_out_valid", bus.out_valid, 1'b0);
        else               check("result", cur, q.pop_front());
      end
      if (bus.in_valid && bus.in_ready) q.push_back(model(bus.op, bus.a, bus.b));
    end
  end

  task automatic send(input logic op, input logic [W-1:0] a, input logic [W-1:0] b);
    int unsigned n;
    logic        acc;
    n = 0;
    bus.in_valid = 1'b1;
    bus.op       = op;
    bus.a        = a;
    bus.b        = b;
    do begin
      @(negedge clk);
      acc = bus.in_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!acc && n < 200);
    if (!acc) begin
      n_cmp++;
      n_bad++;
      $display("FAIL send_timeout: got in_ready=0 for %0d cycles expected acceptance", n);
    end
    bus.in_valid = 1'b0;
  endtask

  // lat counts edges from the accept edge up to the one after which out_valid shows
  task automatic wait_out(input string name, output obs_t o, output int unsigned lat);
    lat = 1;
    while (!bus.out_valid && lat < 50) begin
      @(posedge clk);
      #1;
      lat++;
    end
    if (!bus.out_valid) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s_timeout: got out_valid=0 after %0d cycles expected 1", name, lat);
    end
    o = cur;
  endtask

  initial begin
    obs_t        o;
    int unsigned lat;
    int unsigned sent;
    int unsigned seen;
    logic        acc_prev;

    bus.in_valid   = 1'b0;
    bus.out_ready  = 1'b1;
    bus.op         = OP_ADD;
    bus.a          = '0;
    bus.b          = '0;
    bus_w.in_valid = 1'b0;
    bus_w.out_ready = 1'b1;
    bus_w.op       = OP_ADD;
    bus_w.a        = '0;
    bus_w.b        = '0;
    bus_n.in_valid = 1'b0;
    bus_n.out_ready = 1'b1;
    bus_n.op       = OP_ADD;
    bus_n.a        = '0;
    bus_n.b        = '0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_bit("rst_out_valid", bus.out_valid, 1'b0);
    check("rst_outputs", cur, '0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    check_bit("rst_in_ready", bus.in_ready, 1'b1);
    check("post_rst_outputs", cur, '0);
    @(posedge clk);
    #1;

    // ADD carry across a segment boundary, with latency
    send(OP_ADD, 64'h0000_0000_0000_FFFF, 64'd1);
    wait_out("add", o, lat);
    check("add_latency", 68'(lat), 68'd4);
    check("add_result", o, {64'h0000_0000_0001_0000, 4'b0000});
    @(posedge clk);
    #1;

    // SUB signed overflow
    send(OP_SUB, 64'h8000_0000_0000_0000, 64'd1);
    wait_out("sub_ovf", o, lat);
    check("sub_ovf_result", o, {64'h7FFF_FFFF_FFFF_FFFF, 4'b0011});
    @(posedge clk);
    #1;

    // Two zero results back to back
    send(OP_SUB, 64'd5, 64'd5);
    send(OP_ADD, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1);
    wait_out("zero_pair", o, lat);
    check("zero_first", o, {64'h0, 4'b1001});
    @(posedge clk);
    #1;
    check_bit("zero_second_valid", bus.out_valid, 1'b1);
    check("zero_second", cur, {64'h0, 4'b1001});
    @(posedge clk);
    #1;

    // Six ops with a three-cycle output stall mid-stream
    fork
      begin
        for (int unsigned i = 0; i < 6; i++)
          send(1'(i % 2), 64'h1111_2222_3333_4444 * (i + 1), 64'h0F0F_0F0F_0F0F_0F0F << i);
      end
      begin
        repeat (4) @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        @(posedge clk);
        #1;
        check_bit("stall_out_valid", bus.out_valid, 1'b1);
        check_bit("stall_in_ready", bus.in_ready, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
      end
    join
    repeat (12) @(posedge clk);
    #1;
    check("stall_drained", 68'(q.size()), 68'd0);

    // Reset with three ops in flight; in_valid held high during reset
    send(OP_ADD, 64'd1, 64'd2);
    send(OP_SUB, 64'd9, 64'd3);
    send(OP_ADD, '1, '1);
    rst_n        = 1'b0;
    bus.in_valid = 1'b1;
    bus.a        = 64'd7;
    bus.b        = 64'd7;
    #1;
    check_bit("mid_rst_out_valid", bus.out_valid, 1'b0);
    check("mid_rst_outputs", cur, '0);
    repeat (2) @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    rst_n        = 1'b1;
    seen = 0;
    for (int unsigned i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      if (bus.out_valid) seen++;
    end
    check("post_rst_emitted", 68'(seen), 68'd0);

    // Randomized traffic with random backpressure and input gaps
    sent     = 0;
    acc_prev = 1'b0;
    for (int unsigned c = 0; c < 3000 && sent < 400; c++) begin
      if (!bus.in_valid || acc_prev) begin
        if ($urandom_range(3) != 0) begin
          bus.in_valid = 1'b1;
          bus.op       = 1'($urandom_range(1));
          bus.a        = pick();
          bus.b        = pick();
        end else begin
          bus.in_valid = 1'b0;
        end
      end
      bus.out_ready = ($urandom_range(9) < 7);
      @(negedge clk);
      acc_prev = bus.in_valid && bus.in_ready;
      if (acc_prev) sent++;
      @(posedge clk);
      #1;
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    check("random_drained", 68'(q.size()), 68'd0);

    // Latency of the single-stage and eight-stage configurations
    check_bit("seg64_in_ready", bus_w.in_ready, 1'b1);
    check_bit("seg8_in_ready", bus_n.in_ready, 1'b1);
    bus_w.a = 64'h0000_0000_0000_FFFF;
    bus_w.b = 64'd1;
    bus_n.a = 64'h0000_0000_0000_FFFF;
    bus_n.b = 64'd1;
    bus_w.in_valid = 1'b1;
    bus_n.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus_w.in_valid = 1'b0;
    bus_n.in_valid = 1'b0;
    fork
      begin
        int unsigned l;
        l = 1;
        while (!bus_w.out_valid && l < 40) begin
          @(posedge clk);
          #1;
          l++;
        end
        check("seg64_latency", 68'(l), 68'd1);
        check("seg64_result", cur_w, {64'h0000_0000_0001_0000, 4'b0000});
      end
      begin
        int unsigned l;
        l = 1;
        while (!bus_n.out_valid && l < 40) begin
          @(posedge clk);
          #1;
          l++;
        end
        check("seg8_latency", 68'(l), 68'd8);
        check("seg8_result", cur_n, {64'h0000_0000_0001_0000, 4'b0000});
      end
    join

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1_000_000;
    n_bad++;
    $display("FAIL watchdog: got simulation still running expected completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1);
  end
endmodule
